// File: rtl/uv_sram_dp_arb_pkg.sv
// Shared definitions for the dual-port SRAM arbiter: port-select encoding,
// tag layout constants and a wrap-around index helper.
package uv_sram_dp_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    localparam int PORT_NUM   = 2;
    localparam int TAG_PORT_W = 1;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uv_rr_pick.sv
// Round-robin find-first: first eligible request at or after start, wrapping,
// skipping requesters set in the exclude mask.
module uv_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0] elig;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign elig[gi] = req[gi] & ~excl[gi];
        end
    endgenerate

    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) pos = pos - N;
            if (!found && elig[pos]) begin
                found      = 1'b1;
                idx        = IW'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uv_sram_dp_arb.sv
// Shares one dual-port SRAM between REQ_NUM requesters: up to two round-robin
// grants per cycle (ports A and B), read data returned one cycle after grant.
module uv_sram_dp_arb
    import uv_sram_dp_arb_pkg::*;
#(
    parameter int REQ_NUM = 4,
    parameter int RAM_AW  = 8,
    parameter int RAM_DW  = 32,
    parameter int RAM_MW  = RAM_DW / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_vld,
    output logic [REQ_NUM-1:0]        req_rdy,
    input  logic [REQ_NUM-1:0]        req_we,
    input  logic [REQ_NUM*RAM_AW-1:0] req_addr,
    input  logic [REQ_NUM*RAM_DW-1:0] req_data,
    input  logic [REQ_NUM*RAM_MW-1:0] req_mask,
    output logic [REQ_NUM-1:0]        rsp_vld,
    output logic [REQ_NUM*RAM_DW-1:0] rsp_data,
    output logic                      cea,
    output logic                      wea,
    output logic [RAM_AW-1:0]         aa,
    output logic [RAM_DW-1:0]         da,
    output logic [RAM_MW-1:0]         ma,
    output logic                      ceb,
    output logic                      web,
    output logic [RAM_AW-1:0]         ab,
    output logic [RAM_DW-1:0]         db,
    output logic [RAM_MW-1:0]         mb,
    input  logic [RAM_DW-1:0]         qa,
    input  logic [RAM_DW-1:0]         qb
);

    localparam int REQ_IW = $clog2(REQ_NUM);

    logic [RAM_AW-1:0] addr_arr [REQ_NUM];
    logic [RAM_DW-1:0] data_arr [REQ_NUM];
    logic [RAM_MW-1:0] mask_arr [REQ_NUM];

    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*RAM_AW +: RAM_AW];
            assign data_arr[gi] = req_data[gi*RAM_DW +: RAM_DW];
            assign mask_arr[gi] = req_mask[gi*RAM_MW +: RAM_MW];
        end
    endgenerate

    logic [REQ_IW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [REQ_NUM-1:0] oh_a, oh_b;
    logic [REQ_IW-1:0]  idx_a, idx_b, start_b;
    logic               found_a, found_b;
    logic               conflict, gnt_a, gnt_b;

    uv_rr_pick #(.N(REQ_NUM), .IW(REQ_IW)) u_pick_a (
        .req   (req_vld),
        .start (rr_ptr_reg),
        .excl  ('0),
        .grant (oh_a),
        .idx   (idx_a),
        .found (found_a)
    );

    assign start_b = REQ_IW'(wrap_inc(int'(idx_a), REQ_NUM));

    uv_rr_pick #(.N(REQ_NUM), .IW(REQ_IW)) u_pick_b (
        .req   (req_vld),
        .start (start_b),
        .excl  (oh_a),
        .grant (oh_b),
        .idx   (idx_b),
        .found (found_b)
    );

    // A write may not share an address with the other port's access in one cycle.
    assign conflict = (addr_arr[idx_a] == addr_arr[idx_b]) && (req_we[idx_a] || req_we[idx_b]);
    assign gnt_a    = found_a && !rst;
    assign gnt_b    = found_b && !conflict && !rst;
    assign req_rdy  = ({REQ_NUM{gnt_a}} & oh_a) | ({REQ_NUM{gnt_b}} & oh_b);

    always_comb begin
        cea = gnt_a;
        wea = 1'b0;
        aa  = '0;
        da  = '0;
        ma  = '0;
        ceb = gnt_b;
        web = 1'b0;
        ab  = '0;
        db  = '0;
        mb  = '0;
        if (gnt_a) begin
            wea = req_we[idx_a];
            aa  = addr_arr[idx_a];
            da  = data_arr[idx_a];
            ma  = mask_arr[idx_a];
        end
        if (gnt_b) begin
            web = req_we[idx_b];
            ab  = addr_arr[idx_b];
            db  = data_arr[idx_b];
            mb  = mask_arr[idx_b];
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_b) begin
            rr_ptr_next = REQ_IW'(wrap_inc(int'(idx_b), REQ_NUM));
        end else if (gnt_a) begin
            rr_ptr_next = REQ_IW'(wrap_inc(int'(idx_a), REQ_NUM));
        end
    end

    // One tag slot per SRAM port; slot s records reads issued on that port.
    logic              tag_vld_reg  [PORT_NUM];
    logic [REQ_IW-1:0] tag_id_reg   [PORT_NUM];
    port_sel_e         tag_port_reg [PORT_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            for (int s = 0; s < PORT_NUM; s++) begin
                tag_vld_reg[s]  <= 1'b0;
                tag_id_reg[s]   <= '0;
                tag_port_reg[s] <= PORT_A;
            end
        end else begin
            rr_ptr_reg      <= rr_ptr_next;
            tag_vld_reg[0]  <= gnt_a && !req_we[idx_a];
            tag_id_reg[0]   <= idx_a;
            tag_port_reg[0] <= PORT_A;
            tag_vld_reg[1]  <= gnt_b && !req_we[idx_b];
            tag_id_reg[1]   <= idx_b;
            tag_port_reg[1] <= PORT_B;
        end
    end

    logic [RAM_DW-1:0] q_sel [PORT_NUM];

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_qsel
            assign q_sel[gi] = (tag_port_reg[gi] == PORT_A) ? qa : qb;
        end
        // A requester holds at most one grant per cycle, so at most one slot hits.
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rsp
            logic hit0, hit1;
            assign hit0 = tag_vld_reg[0] && (tag_id_reg[0] == REQ_IW'(gi));
            assign hit1 = tag_vld_reg[1] && (tag_id_reg[1] == REQ_IW'(gi));
            assign rsp_vld[gi] = !rst && (hit0 || hit1);
            assign rsp_data[gi*RAM_DW +: RAM_DW] = hit0 ? q_sel[0] : (hit1 ? q_sel[1] : '0);
        end
    endgenerate

endmodule
